// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch vs load/store arbiter for a single-ported unified RAM
// Optional MEM_ARB_RR_EN: round-robin collision policy instead of fixed data priority.
module mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {OWN_IDLE, OWN_IF, OWN_D} owner_t;

    owner_t           owner, owner_next;
    logic             d_store, d_store_next;
    logic [CNT_W-1:0] starve_cnt, starve_next;
    logic             grant_if, grant_d;
    logic             fetch_pref;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                                d_addr[1:0], d_addr[31:ADDR_W+2]};

`ifdef MEM_ARB_RR_EN
    // last: 1 while data owns the next collision; starts at data, flips with each grant
    logic last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (grant_if) begin
            last <= 1'b1;
        end else if (grant_d) begin
            last <= 1'b0;
        end
    end

    assign fetch_pref = !last || (starve_cnt == CNT_MAX);
`else
    assign fetch_pref = (starve_cnt == CNT_MAX);
`endif

    // Grant is forced off during reset so every output reads 0 while it is held
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!reset) begin
            if (if_valid && (!d_valid || fetch_pref)) begin
                grant_if = 1'b1;
            end else if (d_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        if_ready  = grant_if;
        d_ready   = grant_d;
        mem_en    = grant_if || grant_d;
        mem_we    = (grant_d && d_we) ? d_wstrb : 4'b0000;
        mem_wdata = grant_d ? d_wdata : 32'h0;
        mem_addr  = '0;
        if (grant_if) begin
            mem_addr = if_addr[ADDR_W+1:2];
        end else if (grant_d) begin
            mem_addr = d_addr[ADDR_W+1:2];
        end
    end

    always_comb begin
        owner_next   = OWN_IDLE;
        d_store_next = 1'b0;
        starve_next  = starve_cnt;
        if (grant_if) begin
            owner_next = OWN_IF;
        end else if (grant_d) begin
            owner_next   = OWN_D;
            d_store_next = d_we;
        end
        if (!if_valid || grant_if) begin
            starve_next = '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_IDLE;
            d_store    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            owner      <= owner_next;
            d_store    <= d_store_next;
            starve_cnt <= starve_next;
        end
    end

    // Stores are acknowledged with zero data; the RAM word read alongside is discarded
    assign if_rvalid = (owner == OWN_IF);
    assign d_rvalid  = (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = (d_rvalid && !d_store) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with RAM and reference model
module tb_mem_arbiter;
    localparam int ADDR_W = 8;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_valid, if_ready, if_rvalid;
    logic [31:0]       if_addr, if_rdata;
    logic              d_valid, d_we, d_ready, d_rvalid;
    logic [3:0]        d_wstrb;
    logic [31:0]       d_addr, d_wdata, d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    logic        bd_load = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_valid(d_valid), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_init(int i);
        if (i == 4)   return 32'h00A00513;
        if (i == 100) return 32'h04030201;
        return (32'(i) * 32'h01010101) ^ 32'h9E3779B9;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bd_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        if_valid = 0; if_addr = 0; d_valid = 0; d_we = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        if_valid = 1; d_valid = 1; d_we = 1; d_wstrb = 4'hF;
        bd_load = 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram_init(i);
        @(posedge clk); #1 bd_load = 0;
        @(negedge clk);
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready got %0b want 0", if_ready); end
        n_checks++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL rst_d_ready got %0b want 0", d_ready); end
        n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_if_rvalid got %0b want 0", if_rvalid); end
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_d_rvalid got %0b want 0", d_rvalid); end
        n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata got %h want 0", if_rdata); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata got %h want 0", d_rdata); end
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got %0b want 0", mem_en); end
        n_checks++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL rst_mem_we got %h want 0", mem_we); end
        n_checks++; if (dut.starve_cnt !== '0) begin n_fail++; $display("FAIL rst_starve got %0d want 0", dut.starve_cnt); end
        idle_inputs();
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic test_fetch_alone();
        @(posedge clk); #1 if_valid = 1; if_addr = 32'h10;
        @(negedge clk);
        n_checks++; if (if_ready !== 1'b1 || d_ready !== 1'b0) begin n_fail++; $display("FAIL fa_ready got if=%0b d=%0b want 1/0", if_ready, d_ready); end
        n_checks++; if (mem_addr !== 8'd4 || mem_we !== 4'h0 || mem_en !== 1'b1) begin n_fail++; $display("FAIL fa_port got addr=%0d we=%h en=%0b want 4/0/1", mem_addr, mem_we, mem_en); end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00A00513) begin n_fail++; $display("FAIL fa_resp got v=%0b d=%h want 1/00a00513", if_rvalid, if_rdata); end
        n_checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL fa_d_quiet got v=%0b d=%h want 0/0", d_rvalid, d_rdata); end
    endtask

`ifndef MEM_ARB_RR_EN
    task automatic test_starvation();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 if_valid = 1; if_addr = 32'h20; d_valid = 1; d_we = 0; d_addr = 32'h190;
            @(negedge clk);
            n_checks++; if (if_ready !== (c == 4) || d_ready !== (c != 4)) begin n_fail++; $display("FAIL starve_grant c%0d got if=%0b d=%0b want if=%0b", c, if_ready, d_ready, c == 4); end
            if (c > 0) begin
                n_checks++; if (d_rvalid !== (c != 5) || if_rvalid !== (c == 5)) begin n_fail++; $display("FAIL starve_rvalid c%0d got if=%0b d=%0b", c, if_rvalid, d_rvalid); end
                n_checks++; if (d_rdata !== ((c != 5) ? 32'h04030201 : 32'h0)) begin n_fail++; $display("FAIL starve_rdata c%0d got %h", c, d_rdata); end
            end
        end
        n_checks++; if (dut.starve_cnt !== '0) begin n_fail++; $display("FAIL starve_clear got %0d want 0", dut.starve_cnt); end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
    endtask
`endif

    task automatic test_byte_store();
        @(posedge clk); #1 d_valid = 1; d_we = 1; d_wstrb = 4'b0010; d_addr = 32'h191; d_wdata = 32'h0000AB00;
        @(negedge clk);
        n_checks++; if (d_ready !== 1'b1 || mem_addr !== 8'd100 || mem_we !== 4'b0010) begin n_fail++; $display("FAIL bs_port got rdy=%0b addr=%0d we=%b want 1/100/0010", d_ready, mem_addr, mem_we); end
        n_checks++; if (mem_wdata !== 32'h0000AB00) begin n_fail++; $display("FAIL bs_wdata got %h want 0000ab00", mem_wdata); end
        ref_mem[100] = merge(ref_mem[100], 32'h0000AB00, 4'b0010);
        @(posedge clk); #1 d_we = 0; d_wstrb = 0; d_addr = 32'h190;
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL bs_ack got v=%0b d=%h want 1/0", d_rvalid, d_rdata); end
        @(posedge clk); #1 d_we = 1; d_wstrb = 4'b0000; d_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        n_checks++; if (d_rdata !== 32'h0403AB01) begin n_fail++; $display("FAIL bs_load got %h want 0403ab01", d_rdata); end
        n_checks++; if (d_ready !== 1'b1 || mem_we !== 4'h0) begin n_fail++; $display("FAIL bs_nostrb got rdy=%0b we=%h want 1/0", d_ready, mem_we); end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL bs_nostrb_ack got v=%0b d=%h want 1/0", d_rvalid, d_rdata); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 if_valid = (k < 3); if_addr = 32'(4 * k);
            @(negedge clk);
            n_checks++; if (if_ready !== (k < 3)) begin n_fail++; $display("FAIL b2b_ready k%0d got %0b", k, if_ready); end
            if (k > 0) begin
                n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== ref_mem[k-1]) begin n_fail++; $display("FAIL b2b_resp k%0d got v=%0b d=%h want %h", k, if_rvalid, if_rdata, ref_mem[k-1]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 d_valid = 1; d_we = 0; d_addr = 32'h190; if_valid = 1; if_addr = 32'h10;
        @(negedge clk);
        n_checks++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL rm_grant got %0b want 1", d_ready); end
        #2 reset = 1;
        @(posedge clk); #1;
        n_checks++; if (d_rvalid !== 1'b0 || d_ready !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL rm_outputs got rv=%0b dr=%0b ir=%0b want 0", d_rvalid, d_ready, if_ready); end
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 4'h0 || dut.starve_cnt !== '0) begin n_fail++; $display("FAIL rm_port got en=%0b we=%h cnt=%0d want 0", mem_en, mem_we, dut.starve_cnt); end
        #3 reset = 0;
        @(negedge clk);
        n_checks++; if (d_ready !== 1'b1 || if_ready !== 1'b0) begin n_fail++; $display("FAIL rm_reissue got d=%0b if=%0b want 1/0", d_ready, if_ready); end
        @(posedge clk); #1 d_valid = 0;
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== ref_mem[100]) begin n_fail++; $display("FAIL rm_resp got v=%0b d=%h want %h", d_rvalid, d_rdata, ref_mem[100]); end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00A00513) begin n_fail++; $display("FAIL rm_fetch got v=%0b d=%h", if_rvalid, if_rdata); end
    endtask

`ifdef MEM_ARB_RR_EN
    task automatic test_round_robin();
        logic [3:0] exp_if = 4'b1010;
        reset = 1; idle_inputs();
        @(posedge clk); #1 reset = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1 if_valid = 1; if_addr = 32'h8; d_valid = 1; d_we = 0; d_addr = 32'h4;
            @(negedge clk);
            n_checks++; if (if_ready !== exp_if[c] || d_ready !== !exp_if[c]) begin n_fail++; $display("FAIL rr_grant c%0d got if=%0b d=%0b want if=%0b", c, if_ready, d_ready, exp_if[c]); end
        end
        @(posedge clk); #1 idle_inputs();
    endtask
`endif

    task automatic test_random();
        bit pi = 0, pd = 0, e_if, e_d, rv_if = 0, rv_d = 0, dwe = 0, rr_d = 1;
        logic [31:0] ia = 0, da = 0, dw = 0, rd_if = 0, rd_d = 0;
        logic [3:0] ds = 0;
        int cnt = 0, wait_if = 0;
        reset = 1; idle_inputs();
        @(posedge clk); #1 reset = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!pi && $urandom_range(0, 99) < 60) begin pi = 1; ia = $urandom; end
            if (!pd && $urandom_range(0, 99) < 75) begin
                pd = 1; dwe = $urandom_range(0, 1); ds = 4'($urandom_range(0, 15)); da = $urandom; dw = $urandom;
            end
            if_valid = pi; if_addr = ia; d_valid = pd; d_we = dwe; d_wstrb = ds; d_addr = da; d_wdata = dw;
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            e_if = pi && (!pd || !rr_d);
`else
            e_if = pi && (!pd || cnt == LIMIT);
`endif
            e_d = pd && !e_if;
            n_checks++; if (if_ready !== e_if || d_ready !== e_d || mem_en !== (e_if || e_d)) begin n_fail++; $display("FAIL rnd_grant c%0d got if=%0b d=%0b en=%0b want %0b/%0b", c, if_ready, d_ready, mem_en, e_if, e_d); end
            n_checks++; if (mem_we !== ((e_d && dwe) ? ds : 4'h0)) begin n_fail++; $display("FAIL rnd_we c%0d got %h", c, mem_we); end
            if (e_if || e_d) begin
                n_checks++; if (mem_addr !== (e_if ? ia[9:2] : da[9:2])) begin n_fail++; $display("FAIL rnd_addr c%0d got %0d", c, mem_addr); end
            end
            if (e_d) begin
                n_checks++; if (mem_wdata !== dw) begin n_fail++; $display("FAIL rnd_wdata c%0d got %h want %h", c, mem_wdata, dw); end
            end
            n_checks++; if (if_rvalid !== rv_if || if_rdata !== rd_if) begin n_fail++; $display("FAIL rnd_if_resp c%0d got %0b/%h want %0b/%h", c, if_rvalid, if_rdata, rv_if, rd_if); end
            n_checks++; if (d_rvalid !== rv_d || d_rdata !== rd_d) begin n_fail++; $display("FAIL rnd_d_resp c%0d got %0b/%h want %0b/%h", c, d_rvalid, d_rdata, rv_d, rd_d); end
            rv_if = e_if; rd_if = e_if ? ref_mem[ia[9:2]] : 32'h0;
            rv_d  = e_d;  rd_d  = (e_d && !dwe) ? ref_mem[da[9:2]] : 32'h0;
            if (e_d && dwe) ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], dw, ds);
            cnt = (pi && !e_if) ? ((cnt < LIMIT) ? cnt + 1 : cnt) : 0;
            if (e_if) rr_d = 1; else if (e_d) rr_d = 0;
            if (e_if) begin
                n_checks++; if (wait_if > LIMIT) begin n_fail++; $display("FAIL rnd_starve_bound c%0d waited %0d max %0d", c, wait_if, LIMIT); end
                wait_if = 0; pi = 0;
            end else if (pi) begin
                wait_if++;
            end
            if (e_d) pd = 0;
        end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch_alone();
`ifndef MEM_ARB_RR_EN
        test_starvation();
`endif
        test_byte_store();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_ARB_RR_EN
        test_round_robin();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
